interp_phase_sched: RTL and testbench

INTERP_PHASE_SCHED -- requirements
Module: interp_phase_sched

---
 rtl/interp_phase_sched.sv | 136 +++++++++++++
 tb/tb_interp_phase_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/interp_phase_sched.sv
// Control scheduler for a polyphase interpolator: accepts one input sample, waits out
// the filter latency, then emits L output beats, one per polyphase branch.
module interp_phase_sched #(
    parameter int MAX_PHASES = 8,
    parameter int FILT_LAT   = 2,
    parameter int PHASE_W    = $clog2(MAX_PHASES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         rate_sel,
    input  logic               bypass,
    input  logic               src_valid_in,
    output logic               src_ready_out,
    output logic               dst_valid_out,
    input  logic               dst_ready_in,
    output logic               en_out,
    output logic [PHASE_W-1:0] phase_out,
    output logic               busy,
    output logic               rate_err
);

    localparam int CNT_W = (FILT_LAT > 1) ? $clog2(FILT_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FILT_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_EMIT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] last_q, last_d;
    logic               rate_err_q, rate_err_d;
    logic               load;

    // The reserved code 11 runs at the highest rate, L = 8.
    function automatic logic [PHASE_W-1:0] last_phase(input logic [1:0] sel);
        case (sel)
            2'b00:   return PHASE_W'(1);
            2'b01:   return PHASE_W'(3);
            default: return PHASE_W'(7);
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        cnt_d         = cnt_q;
        phase_d       = phase_q;
        last_d        = last_q;
        rate_err_d    = rate_err_q;
        src_ready_out = 1'b0;
        dst_valid_out = 1'b0;
        en_out        = 1'b0;
        load          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bypass) begin
                    dst_valid_out = src_valid_in;
                    src_ready_out = dst_ready_in;
                end else begin
                    src_ready_out = 1'b1;
                    load          = src_valid_in;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    en_out  = 1'b1;
                    state_d = S_EMIT;
                    phase_d = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_EMIT: begin
                dst_valid_out = 1'b1;
                if (phase_q == last_q) begin
                    // Last beat: the next sample may be taken in the same handshake cycle.
                    src_ready_out = dst_ready_in;
                    if (dst_ready_in) begin
                        phase_d = '0;
                        if (src_valid_in) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end else if (dst_ready_in) begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
            phase_d = '0;
            last_d  = last_phase(rate_sel);
            if (rate_sel == 2'b11) begin
                rate_err_d = 1'b1;
            end
        end

        if (rst) begin
            src_ready_out = 1'b0;
            dst_valid_out = 1'b0;
            en_out        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            phase_q    <= '0;
            last_q     <= PHASE_W'(1);
            rate_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            last_q     <= last_d;
            rate_err_q <= rate_err_d;
        end
    end

    assign phase_out = phase_q;
    assign busy      = (state_q != S_IDLE);
    assign rate_err  = rate_err_q;

endmodule

// File: tb/tb_interp_phase_sched.sv
// Bench for interp_phase_sched: directed scenarios with literal expectations, then random
// traffic compared every cycle against a sample/latency-based reference model.
module tb_interp_phase_sched;

    localparam int FILT_LAT = 2;
    localparam int PHASE_W  = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         rate_sel;
    logic               bypass;
    logic               src_valid_in;
    logic               src_ready_out;
    logic               dst_valid_out;
    logic               dst_ready_in;
    logic               en_out;
    logic [PHASE_W-1:0] phase_out;
    logic               busy;
    logic               rate_err;

    int tests  = 0;
    int failed = 0;
    bit chk_en = 1'b0;

    interp_phase_sched #(
        .MAX_PHASES(8),
        .FILT_LAT  (FILT_LAT),
        .PHASE_W   (PHASE_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rate_sel     (rate_sel),
        .bypass       (bypass),
        .src_valid_in (src_valid_in),
        .src_ready_out(src_ready_out),
        .dst_valid_out(dst_valid_out),
        .dst_ready_in (dst_ready_in),
        .en_out       (en_out),
        .phase_out    (phase_out),
        .busy         (busy),
        .rate_err     (rate_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a sample in flight, cycles elapsed since its accept, rate, beats done.
    bit m_in_flight = 1'b0;
    int m_cyc       = 0;
    int m_rate      = 2;
    int m_beats     = 0;
    bit m_err       = 1'b0;

    typedef struct packed {
        logic        v;
        logic        r;
        logic        e;
        logic        b;
        logic        err;
        logic [31:0] ph;
    } exp_t;

    function automatic exp_t expect_now();
        exp_t x;
        bit   emitting;
        emitting = m_in_flight && (m_cyc > FILT_LAT);
        x.b   = m_in_flight;
        x.err = m_err;
        x.ph  = m_beats;
        x.e   = !rst && m_in_flight && (m_cyc == FILT_LAT);
        x.v   = !rst && (m_in_flight ? emitting : (bypass && src_valid_in));
        x.r   = !rst && (m_in_flight ? (emitting && (m_beats == m_rate - 1) && dst_ready_in)
                                     : (bypass ? dst_ready_in : 1'b1));
        return x;
    endfunction

    function automatic int rate_of(input logic [1:0] sel);
        return (sel == 2'd0) ? 2 : (sel == 2'd1) ? 4 : 8;
    endfunction

    always @(posedge clk) begin
        exp_t x;
        bit   acc;
        x = expect_now();
        if (rst) begin
            m_in_flight = 1'b0;
            m_cyc       = 0;
            m_rate      = 2;
            m_beats     = 0;
            m_err       = 1'b0;
        end else begin
            acc = src_valid_in && x.r;
            if (m_in_flight) begin
                if (x.v && dst_ready_in) begin
                    if (m_beats == m_rate - 1) begin
                        m_in_flight = 1'b0;
                        m_beats     = 0;
                    end else begin
                        m_beats++;
                    end
                end else if (m_cyc <= FILT_LAT) begin
                    m_cyc++;
                end
            end
            if (acc && !(bypass && !x.b)) begin
                m_in_flight = 1'b1;
                m_cyc       = 1;
                m_beats     = 0;
                m_rate      = rate_of(rate_sel);
                if (rate_sel == 2'd3) m_err = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t x;
        if (chk_en) begin
            x = expect_now();
            check("dst_valid", 32'(dst_valid_out), 32'(x.v));
            check("src_ready", 32'(src_ready_out), 32'(x.r));
            check("en_out",    32'(en_out),        32'(x.e));
            check("busy",      32'(busy),          32'(x.b));
            check("rate_err",  32'(rate_err),      32'(x.err));
            check("phase",     32'(phase_out),     x.ph);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int beats;
        rst          = 1'b1;
        rate_sel     = 2'd0;
        bypass       = 1'b0;
        src_valid_in = 1'b0;
        dst_ready_in = 1'b1;
        step();
        step();
        chk_en = 1'b1;

        // L=2, FILT_LAT=2: accept at T, en_out at T+2, beats at T+3 and T+4.
        rst          = 1'b0;
        src_valid_in = 1'b1;
        #1;
        check("a_ready_idle", 32'(src_ready_out), 1);
        check("a_busy_idle",  32'(busy), 0);
        step();
        src_valid_in = 1'b0;
        #1;
        check("a_en_t1",   32'(en_out), 0);
        check("a_busy_t1", 32'(busy), 1);
        step(); #1;
        check("a_en_t2", 32'(en_out), 1);
        step(); #1;
        check("a_valid_t3", 32'(dst_valid_out), 1);
        check("a_phase_t3", 32'(phase_out), 0);
        check("a_ready_t3", 32'(src_ready_out), 0);
        step(); #1;
        check("a_valid_t4", 32'(dst_valid_out), 1);
        check("a_phase_t4", 32'(phase_out), 1);
        check("a_ready_t4", 32'(src_ready_out), 1);
        step(); #1;
        check("a_valid_t5", 32'(dst_valid_out), 0);
        check("a_busy_t5",  32'(busy), 0);

        // Reserved rate: eight beats, sticky error; then bypass in IDLE.
        rate_sel     = 2'd3;
        src_valid_in = 1'b1;
        step();
        src_valid_in = 1'b0;
        rate_sel     = 2'd0;
        #1;
        check("b_err_set", 32'(rate_err), 1);
        beats = 0;
        repeat (14) begin
            step(); #1;
            if (dst_valid_out) beats++;
        end
        check("b_beats", beats, 8);
        check("b_err_hold", 32'(rate_err), 1);
        bypass       = 1'b1;
        src_valid_in = 1'b1;
        dst_ready_in = 1'b0;
        #1;
        check("b_byp_valid", 32'(dst_valid_out), 1);
        check("b_byp_ready0", 32'(src_ready_out), 0);
        check("b_byp_en", 32'(en_out), 0);
        dst_ready_in = 1'b1;
        #1;
        check("b_byp_ready1", 32'(src_ready_out), 1);
        step(); #1;
        check("b_byp_busy", 32'(busy), 0);
        bypass       = 1'b0;
        src_valid_in = 1'b0;
        rst          = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("b_err_clr", 32'(rate_err), 0);

        // Continuous input at L=4: back-to-back samples keep busy high.
        rate_sel     = 2'd1;
        src_valid_in = 1'b1;
        step();
        repeat (24) begin
            step(); #1;
            check("c_busy", 32'(busy), 1);
        end
        src_valid_in = 1'b0;
        repeat (12) step();

        // Reset at phase 1 of an L=8 sample discards it.
        rate_sel     = 2'd2;
        src_valid_in = 1'b1;
        step();
        src_valid_in = 1'b0;
        repeat (3) step();
        check("d_phase1", 32'(phase_out), 1);
        check("d_valid1", 32'(dst_valid_out), 1);
        rst = 1'b1;
        #1;
        check("d_rst_valid", 32'(dst_valid_out), 0);
        check("d_rst_ready", 32'(src_ready_out), 0);
        step();
        rst = 1'b0;
        #1;
        check("d_post_valid", 32'(dst_valid_out), 0);
        check("d_post_phase", 32'(phase_out), 0);
        check("d_post_busy",  32'(busy), 0);

        // Random traffic against the model.
        repeat (3000) begin
            step();
            rst          = ($urandom_range(0, 199) == 0);
            bypass       = ($urandom_range(0, 9) == 0);
            src_valid_in = ($urandom_range(0, 9) < 7);
            dst_ready_in = ($urandom_range(0, 3) != 0);
            rate_sel     = 2'($urandom_range(0, 3));
        end
        step();
        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
